// File: rtl/mac2fifod_if.sv
// Bus bundle between mac2fifod, the mac receive buffer port and the receive FIFO write side.
// Handshake: fs is a level request held by mac; fd acknowledges until fs falls; fifod_full is back-pressure sampled only when an address is issued.
interface mac2fifod_if #(
  parameter int ADDR_W = 11
) ();
  logic              fs;
  logic              fd;
  logic [15:0]       udp_rx_len;
  logic [ADDR_W-1:0] udp_rx_addr;
  logic [7:0]        udp_rxd;
  logic              fifod_full;
  logic              fifod_txen;
  logic [7:0]        fifod_txd;
  logic              err;

  modport master (
    input  fs, udp_rx_len, udp_rxd, fifod_full,
    output fd, udp_rx_addr, fifod_txen, fifod_txd, err
  );

  modport slave (
    output fs, udp_rx_len, udp_rxd, fifod_full,
    input  fd, udp_rx_addr, fifod_txen, fifod_txd, err
  );
endinterface

// File: rtl/mac2fifod.sv
// UDP receive payload mover: reads udp_rx_len bytes from the mac buffer by address into a FIFO.
// Optional MAC2FIFOD_LEN_HDR_EN prefixes each packet with a 2-byte big-endian length header.
module mac2fifod #(
  parameter int ADDR_W  = 11,
  parameter int MAX_LEN = 1472
) (
  input  logic          clk,
  input  logic          rst_n,
  mac2fifod_if.master   bus,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    FLUSH = 3'd2,
    DONE  = 3'd3,
    HDR   = 3'd4
  } state_t;

  localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

  state_t            state, state_d;
  logic [15:0]       len;
  logic [15:0]       len_in;
  logic [ADDR_W-1:0] cnt;
  logic              iss;
  logic              v1;
  logic              issue;
  logic              load;
  logic              err_d;
  logic              hdr_wr;
  logic [7:0]        hdr_byte;
  logic              last_issue;
`ifdef MAC2FIFOD_LEN_HDR_EN
  logic              hdr_idx;
`endif

  assign len_in     = (bus.udp_rx_len > MAX_LEN16) ? MAX_LEN16 : bus.udp_rx_len;
  assign last_issue = (16'(cnt) == (len - 16'd1));
  assign bus.fd     = (state == DONE);
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    issue    = 1'b0;
    load     = 1'b0;
    err_d    = 1'b0;
    hdr_wr   = 1'b0;
    hdr_byte = 8'h00;
    case (state)
      IDLE: begin
        if (bus.fs) begin
          load  = 1'b1;
          err_d = (bus.udp_rx_len > MAX_LEN16);
`ifdef MAC2FIFOD_LEN_HDR_EN
          state_d = HDR;
`else
          state_d = (len_in == 16'd0) ? DONE : READ;
`endif
        end
      end
`ifdef MAC2FIFOD_LEN_HDR_EN
      HDR: begin
        if (!bus.fs) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (!bus.fifod_full) begin
          hdr_wr   = 1'b1;
          hdr_byte = hdr_idx ? len[7:0] : len[15:8];
          if (hdr_idx) state_d = (len == 16'd0) ? DONE : READ;
        end
      end
`endif
      READ: begin
        if (!bus.fs) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (!bus.fifod_full) begin
          issue = 1'b1;
          if (last_issue) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Abort wins even if the pipeline already drained: fs falling here is a lost packet.
        if (!bus.fs) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (!iss && !v1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.fs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-stage read pipeline: iss rides with the address, v1 lines up with udp_rxd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len             <= 16'd0;
      cnt             <= '0;
      iss             <= 1'b0;
      v1              <= 1'b0;
      bus.udp_rx_addr <= '0;
      bus.fifod_txen  <= 1'b0;
      bus.fifod_txd   <= 8'h00;
      bus.err         <= 1'b0;
`ifdef MAC2FIFOD_LEN_HDR_EN
      hdr_idx         <= 1'b0;
`endif
    end else begin
      if (load) begin
        len <= len_in;
        cnt <= '0;
`ifdef MAC2FIFOD_LEN_HDR_EN
        hdr_idx <= 1'b0;
`endif
      end
      if (issue) begin
        bus.udp_rx_addr <= cnt;
        cnt             <= cnt + 1'b1;
      end
`ifdef MAC2FIFOD_LEN_HDR_EN
      if (hdr_wr) hdr_idx <= 1'b1;
`endif
      iss            <= issue;
      v1             <= iss;
      bus.fifod_txen <= v1 | hdr_wr;
      if (hdr_wr)  bus.fifod_txd <= hdr_byte;
      else if (v1) bus.fifod_txd <= bus.udp_rxd;
      bus.err        <= err_d;
    end
  end

endmodule

// File: tb/tb_mac2fifod.sv
// Directed bench for mac2fifod: buffer model, write scoreboard and hand-computed timing checks.
module tb_mac2fifod;
  localparam int ADDR_W  = 11;
  localparam int MAX_LEN = 1472;
`ifdef MAC2FIFOD_LEN_HDR_EN
  localparam int HDR_N = 2;
`else
  localparam int HDR_N = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  mac2fifod_if #(.ADDR_W(ADDR_W)) bus ();

  mac2fifod #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) bus.udp_rxd <= mem[bus.udp_rx_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         wr_cnt = 0;
  int         err_cnt = 0;
  int         first_wr_cyc = -1;
  int         last_wr_cyc = -1;
  bit         fd_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every FIFO write is popped against the expected byte stream.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fifod_txen) begin
        wr_cnt++;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) check("extra_write", 32'(bus.fifod_txd), 32'hFFFF_FFFF);
        else                   check("wr_data", 32'(bus.fifod_txd), 32'(exp_q.pop_front()));
      end
      if (bus.err) err_cnt++;
      if (bus.fd)  fd_seen = 1'b1;
    end
  end

  task automatic clear_stats();
    wr_cnt = 0;
    err_cnt = 0;
    first_wr_cyc = -1;
    last_wr_cyc = -1;
    fd_seen = 1'b0;
  endtask

  task automatic push_exp(input int hdr_len, input int n);
    logic [15:0] l;
    l = 16'(hdr_len);
`ifdef MAC2FIFOD_LEN_HDR_EN
    exp_q.push_back(l[15:8]);
    exp_q.push_back(l[7:0]);
`endif
    for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
  endtask

  task automatic start_pkt(input int rlen, output int c0);
    @(negedge clk);
    bus.fs = 1'b1;
    bus.udp_rx_len = 16'(rlen);
    c0 = cyc;
  endtask

  task automatic wait_fd(input string tag, input int bound, input int exp_wr);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.fd && n < bound);
    check({tag, "_fd_rise"}, 32'(bus.fd), 32'd1);
    check({tag, "_wr_count"}, 32'(wr_cnt), 32'(exp_wr));
  endtask

  task automatic end_pkt(input string tag);
    @(negedge clk);
    bus.fs = 1'b0;
    @(negedge clk);
    check({tag, "_fd_fall"}, 32'(bus.fd), 32'd0);
    check({tag, "_exp_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int extra;

    for (int i = 0; i < (1 << ADDR_W); i++)
      mem[i] = (i < 12) ? 8'(i) : 8'(i * 37 + 11 + (i >> 8));
    bus.fs = 1'b0;
    bus.udp_rx_len = 16'd0;
    bus.fifod_full = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_fd",    32'(bus.fd), 32'd0);
    check("rst_addr",  32'(bus.udp_rx_addr), 32'd0);
    check("rst_txen",  32'(bus.fifod_txen), 32'd0);
    check("rst_txd",   32'(bus.fifod_txd), 32'd0);
    check("rst_err",   32'(bus.err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // 12-byte packet: first write 4 negedges after fs, writes back to back.
    clear_stats();
    push_exp(12, 12);
    start_pkt(12, c0);
    wait_fd("t1", 40, 12 + HDR_N);
    check("t1_latency", 32'(first_wr_cyc - c0), 32'(4 - HDR_N));
    check("t1_span",    32'(last_wr_cyc - first_wr_cyc), 32'(11 + 2 * HDR_N));
    check("t1_addr",    32'(bus.udp_rx_addr), 32'd11);
    check("t1_err",     32'(err_cnt), 32'd0);
    end_pkt("t1");

    // Zero length.
    clear_stats();
    push_exp(0, 0);
    start_pkt(0, c0);
    wait_fd("t2", 2 + HDR_N, HDR_N);
    check("t2_err", 32'(err_cnt), 32'd0);
    end_pkt("t2");

    // Oversized length is clamped to MAX_LEN.
    clear_stats();
    push_exp(MAX_LEN, MAX_LEN);
    start_pkt(2000, c0);
    wait_fd("t3", 1600, MAX_LEN + HDR_N);
    check("t3_err_pulse", 32'(err_cnt), 32'd1);
    check("t3_addr",      32'(bus.udp_rx_addr), 32'd1471);
    end_pkt("t3");

    // Back-pressure for 10 clk from the 5th issue: only the 2 in-flight bytes land.
    clear_stats();
    push_exp(64, 64);
    start_pkt(64, c0);
    repeat (5 + HDR_N) @(negedge clk);
    bus.fifod_full = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.fifod_txen) extra++;
    end
    check("t4_hold_addr", 32'(bus.udp_rx_addr), 32'd3);
    bus.fifod_full = 1'b0;
    check("t4_writes_while_full", 32'(extra), 32'd2);
    wait_fd("t4", 200, 64 + HDR_N);
    check("t4_err", 32'(err_cnt), 32'd0);
    end_pkt("t4");

    // Abort after 20 issues of a 100-byte packet.
    clear_stats();
    push_exp(100, 20);
    start_pkt(100, c0);
    repeat (21 + HDR_N) @(negedge clk);
    bus.fs = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_wr_count",  32'(wr_cnt), 32'(20 + HDR_N));
    check("t5_err_pulse", 32'(err_cnt), 32'd1);
    check("t5_no_fd",     32'(fd_seen), 32'd0);
    check("t5_state",     32'(dbg_state), 32'd0);
    check("t5_addr",      32'(bus.udp_rx_addr), 32'd19);
    check("t5_exp_empty", 32'(exp_q.size()), 32'd0);
    clear_stats();
    push_exp(4, 4);
    start_pkt(4, c0);
    wait_fd("t5b", 20, 4 + HDR_N);
    check("t5b_err", 32'(err_cnt), 32'd0);
    end_pkt("t5b");

    // Reset mid-READ clears outputs asynchronously; block then waits for fs.
    clear_stats();
    push_exp(50, 50);
    start_pkt(50, c0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_fd",    32'(bus.fd), 32'd0);
    check("t6_addr",  32'(bus.udp_rx_addr), 32'd0);
    check("t6_txen",  32'(bus.fifod_txen), 32'd0);
    check("t6_txd",   32'(bus.fifod_txd), 32'd0);
    check("t6_err",   32'(bus.err), 32'd0);
    check("t6_state", 32'(dbg_state), 32'd0);
    exp_q.delete();
    bus.fs = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    repeat (6) @(negedge clk);
    check("t6_idle_state", 32'(dbg_state), 32'd0);
    check("t6_idle_wr",    32'(wr_cnt), 32'd0);
    check("t6_idle_addr",  32'(bus.udp_rx_addr), 32'd0);

    // Short packet after reset (carries the length header when enabled).
    clear_stats();
    push_exp(3, 3);
    start_pkt(3, c0);
    wait_fd("t7", 20, 3 + HDR_N);
    end_pkt("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac2fifod.md
Name: mac2fifod

Overview:
- UDP receive-side payload mover; the receive counterpart of the fifod2mac transmit path.
- Sits between the mac receive buffer port and the write side of a receive FIFO (fifod instance), all in the gmii_rxc domain.
- When mac signals a received UDP packet with fs, the block reads udp_rx_len payload bytes from the mac buffer by address and pushes them into the FIFO.
- It reports completion with fd and flags bad lengths or aborts on err.

Parameters:
- ADDR_W, 11, width of udp_rx_addr (mac receive buffer depth 2^ADDR_W bytes).
- MAX_LEN, 1472, largest payload accepted; longer lengths are clamped.

Ports:
- clk  input  1  gmii_rxc receive clock.
- rst_n  input  1  asynchronous active-low reset.
- fs  input  1  from mac (fs_udp_rx); level, high while a received payload is available.
- fd  output  1  to mac (fd_udp_rx); high from packet done until fs falls.
- udp_rx_len  input  16  payload byte count, valid while fs is high.
- udp_rx_addr  output  ADDR_W  read address into the mac receive buffer.
- udp_rxd  input  8  buffer read data, valid one clk after udp_rx_addr.
- fifod_full  input  1  FIFO programmable almost-full, asserted with at least 2 free slots remaining.
- fifod_txen  output  1  FIFO write enable.
- fifod_txd  output  8  FIFO write data.
- err  output  1  one-cycle pulse on a clamped length or an aborted packet.

Behaviour:
- Reset (async, rst_n=0): state IDLE; fd=0, udp_rx_addr=0, fifod_txen=0, fifod_txd=0, err=0, all counters 0.
- Reset is honoured at any time, including mid-packet. Bytes already written to the FIFO stay there; the FIFO is not reset by this block.
- States: IDLE, READ, FLUSH, DONE.
- IDLE:
  - On clk with fs=1, latch len = min(udp_rx_len, MAX_LEN).
  - If udp_rx_len > MAX_LEN, pulse err in the same cycle.
  - len=0 goes to DONE; otherwise go to READ with addr counter = 0.
- READ:
  - Each cycle with fifod_full=0, drive udp_rx_addr = counter, mark the issue valid, and increment the counter.
  - With fifod_full=1, issue nothing and hold the counter.
  - After issuing address len-1, go to FLUSH.
- Pipeline, fixed 2 stages:
  - Stage 1: the issue-valid flag is delayed one clk to align with udp_rxd.
  - Stage 2: udp_rxd is registered onto fifod_txd with fifod_txen=1.
  - Latency from an address issue to fifod_txen high is 2 clk. Example: first address issued at cycle 1 gives the first write at cycle 3.
  - In-flight bytes (at most 2) are always written, even if fifod_full rises; the FIFO's 2-slot margin covers them.
- FLUSH: wait until both pipeline valid flags are 0, then go to DONE.
- DONE: fd=1; stay until fs=0, then go to IDLE with fd=0. A new packet cannot start until fs has been low for at least one clk.
- Abort: fs=0 while in READ or FLUSH.
  - Stop issuing addresses; in-flight bytes are still written.
  - Pulse err, go to IDLE, and never assert fd.
- Width rules:
  - The addr counter is ADDR_W bits and never wraps, because MAX_LEN < 2^ADDR_W.
  - len is held in 16 bits internally.
- Writes: exactly len fifod_txen pulses per completed packet, in address order 0..len-1, never more.

Optional Feature:
- Macro MAC2FIFOD_LEN_HDR_EN.
- Defined:
  - Before payload byte 0, write two header bytes into the FIFO: len[15:8], then len[7:0]. The value is the clamped len.
  - Each header byte is written only in a cycle with fifod_full=0.
  - For len=0, only the 2 header bytes are written, then DONE.
  - Payload timing shifts 2 cycles later.
- Undefined: raw payload only, as described above.

Test Plan:
- Reset then fs=1, udp_rx_len=12, buffer holds 0x00..0x0B, fifod_full=0 -> addresses 0..11 on consecutive clk; 12 fifod_txen pulses carrying 0x00..0x0B, the first 2 clk after address 0; fd=1 after the last write; fd=0 one clk after fs drops.
- len=0 -> no fifod_txen, fd=1 within 2 clk, err stays 0.
- udp_rx_len=2000 -> err pulse for 1 clk; exactly 1472 writes; final udp_rx_addr=1471; fd asserts.
- len=64 with fifod_full forced high for 10 clk starting at the 5th issue -> address issue halts, at most 2 further writes occur, resume continues without loss or duplication, total 64 bytes in order.
- fs dropped after 20 issues of a 100-byte packet -> err pulse, at most 22 writes, fd never asserted, back in IDLE; the next packet (len=4) transfers correctly.
- rst_n low mid-READ of a 50-byte packet -> all outputs 0 immediately; after release, the block stays in IDLE until fs is seen. With MAC2FIFOD_LEN_HDR_EN defined and len=3, the FIFO receives 0x00, 0x03, b0, b1, b2.
